// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: multi-cycle processor sequencer.
// Flow: FETCH -> DECODE -> EXE -> [MEM] -> WB, with a bounded memory
// request/acknowledge handshake, EXE stall, optional MEM bypass, halt and
// a sticky timeout error.
// Optional build macro PROC_SEQ_PERF_EN adds 32-bit cycle, instruction
// and stall counters; without it those ports and registers do not exist.
module proc_seq_ctrl #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 10,
    parameter bit SKIP_MEM = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              NEED_MEM,
    input  logic              IS_STORE,
    input  logic              STALL,
    input  logic              MEM_ACK,
    input  logic              HALT_REQ,
    output logic [2:0]        STATE,
    output logic              MEM_REQ,
    output logic              MEM_WR,
    output logic              INSTR_DONE,
    output logic              ERR,
    output logic [WAIT_W-1:0] WAIT_CNT
`ifdef PROC_SEQ_PERF_EN
    ,
    output logic [31:0]       CYCLE_CNT,
    output logic [31:0]       INSTR_CNT,
    output logic [31:0]       STALL_CNT
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                need_mem_q, need_mem_d;
    logic                is_store_q, is_store_d;
    logic                err_q, err_d;
    logic                req_pending;

    // A memory request is outstanding in FETCH always, and in MEM only
    // when the instruction latched in EXE actually touches memory.
    always_comb begin
        req_pending = 1'b0;
        if (state_q == S_FETCH) begin
            req_pending = 1'b1;
        end else if (state_q == S_MEM) begin
            req_pending = need_mem_q;
        end
    end

    // Next-state logic: handshake with wait counting and timeout, EXE
    // stall and operand latching, halt decision in WB.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        need_mem_d = need_mem_q;
        is_store_d = is_store_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH, S_MEM: begin
                if (req_pending) begin
                    if (MEM_ACK) begin
                        state_d = (state_q == S_FETCH) ? S_DECODE : S_WB;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end else if (wait_cnt_q != WAIT_SAT) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_DECODE: begin
                state_d = S_EXE;
            end
            S_EXE: begin
                if (!STALL) begin
                    need_mem_d = NEED_MEM;
                    is_store_d = IS_STORE;
                    state_d    = (NEED_MEM || !SKIP_MEM) ? S_MEM : S_WB;
                end
            end
            S_WB: begin
                state_d = HALT_REQ ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end
    end

    // Core state register with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            need_mem_q <= 1'b0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            need_mem_q <= need_mem_d;
            is_store_q <= is_store_d;
            err_q      <= err_d;
        end
    end

    // Moore outputs decoded from the registered state and latches only.
    always_comb begin
        STATE      = state_q;
        MEM_REQ    = req_pending;
        MEM_WR     = (state_q == S_MEM) && need_mem_q && is_store_q;
        INSTR_DONE = (state_q == S_WB);
        ERR        = err_q;
        WAIT_CNT   = wait_cnt_q;
    end

`ifdef PROC_SEQ_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter increments: active cycles, retired instructions, and cycles
    // lost to an EXE stall or an unacknowledged memory request.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q != S_IDLE && state_q != S_HALT) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (state_q == S_WB) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
        if ((state_q == S_EXE && STALL) || (req_pending && !MEM_ACK)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Performance counter registers, wrapping naturally at 2^32.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign CYCLE_CNT = cycle_cnt_q;
    assign INSTR_CNT = instr_cnt_q;
    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Testbench for proc_seq_ctrl. Two instances: unit 0 uses the default
// parameters (MAX_WAIT=10, MEM bypass on), unit 1 uses WAIT_W=2,
// MAX_WAIT=3 with MEM always visited. Each instruction is described at the
// transaction level (fetch delay, stall length, memory use, memory delay,
// halt) and expanded into an expected per-cycle trace which is then
// replayed against the selected unit.
module tb_proc_seq_ctrl;

    logic        clk = 1'b0;
    logic [1:0]  rstN = 2'b00;
    logic [1:0]  needIn = 2'b00;
    logic [1:0]  storeIn = 2'b00;
    logic [1:0]  stallIn = 2'b00;
    logic [1:0]  ackIn = 2'b00;
    logic [1:0]  haltIn = 2'b00;
    logic [2:0]  stateOut [2];
    logic [1:0]  reqOut;
    logic [1:0]  wrOut;
    logic [1:0]  doneOut;
    logic [1:0]  errOut;
    logic [3:0]  waitOut0;
    logic [1:0]  waitOut1;
`ifdef PROC_SEQ_PERF_EN
    logic [31:0] cycOut [2];
    logic [31:0] insOut [2];
    logic [31:0] stlOut [2];
`endif

    int totalChecks = 0;
    int badChecks = 0;

    int maxWait [2] = '{10, 3};
    bit skipMem [2] = '{1'b1, 1'b0};

    typedef struct {
        logic       ack;
        logic       stall;
        logic       need;
        logic       store;
        logic       halt;
        logic [2:0] st;
        logic       req;
        logic       wr;
        logic       done;
        logic       err;
        int         wcnt;
    } cyc_t;

    cyc_t trace [$];
    bit   traceEnded;

    // Free-running clock shared by both units.
    always #5 clk = ~clk;

    proc_seq_ctrl #(.WAIT_W(4), .MAX_WAIT(10), .SKIP_MEM(1'b1)) dut0 (
        .CLK(clk), .RST(rstN[0]), .NEED_MEM(needIn[0]), .IS_STORE(storeIn[0]),
        .STALL(stallIn[0]), .MEM_ACK(ackIn[0]), .HALT_REQ(haltIn[0]),
        .STATE(stateOut[0]), .MEM_REQ(reqOut[0]), .MEM_WR(wrOut[0]),
        .INSTR_DONE(doneOut[0]), .ERR(errOut[0]), .WAIT_CNT(waitOut0)
`ifdef PROC_SEQ_PERF_EN
        , .CYCLE_CNT(cycOut[0]), .INSTR_CNT(insOut[0]), .STALL_CNT(stlOut[0])
`endif
    );

    proc_seq_ctrl #(.WAIT_W(2), .MAX_WAIT(3), .SKIP_MEM(1'b0)) dut1 (
        .CLK(clk), .RST(rstN[1]), .NEED_MEM(needIn[1]), .IS_STORE(storeIn[1]),
        .STALL(stallIn[1]), .MEM_ACK(ackIn[1]), .HALT_REQ(haltIn[1]),
        .STATE(stateOut[1]), .MEM_REQ(reqOut[1]), .MEM_WR(wrOut[1]),
        .INSTR_DONE(doneOut[1]), .ERR(errOut[1]), .WAIT_CNT(waitOut1)
`ifdef PROC_SEQ_PERF_EN
        , .CYCLE_CNT(cycOut[1]), .INSTR_CNT(insOut[1]), .STALL_CNT(stlOut[1])
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Random bit used for inputs the design is supposed to ignore.
    function automatic logic rb();
        return logic'($urandom % 2);
    endfunction

    function automatic logic [31:0] obsWait(input int u);
        return (u == 0) ? 32'(waitOut0) : 32'(waitOut1);
    endfunction

    // Append one expected cycle together with the inputs driven in it.
    task automatic addCyc(input logic [2:0] st, input logic req, input logic wr,
                          input logic done, input logic err, input int w,
                          input logic ack, input logic stall, input logic need,
                          input logic store, input logic halt);
        cyc_t c;
        c.st = st; c.req = req; c.wr = wr; c.done = done; c.err = err;
        c.wcnt = w; c.ack = ack; c.stall = stall; c.need = need;
        c.store = store; c.halt = halt;
        trace.push_back(c);
    endtask

    // A halted sequencer sits in state 6 regardless of its inputs.
    task automatic addHalt(input logic err);
        repeat (3) addCyc(3'd6, 1'b0, 1'b0, 1'b0, err, 0, rb(), rb(), rb(), rb(), rb());
        traceEnded = 1'b1;
    endtask

    // A memory handshake acknowledged after 'delay' wait cycles, or a
    // timeout once the tolerated number of wait cycles has elapsed.
    task automatic addHandshake(input int u, input logic [2:0] st, input int delay,
                                input logic wr, output bit timedOut);
        timedOut = 1'b0;
        for (int k = 0; k <= maxWait[u]; k++) begin
            if (k == delay) begin
                addCyc(st, 1'b1, wr, 1'b0, 1'b0, k, 1'b1, rb(), rb(), rb(), rb());
                return;
            end
            addCyc(st, 1'b1, wr, 1'b0, 1'b0, k, 1'b0, rb(), rb(), rb(), rb());
        end
        timedOut = 1'b1;
    endtask

    // Expand one instruction description into expected cycles.
    task automatic genInstr(input int u, input int fDelay, input int stalls,
                            input logic need, input logic store, input int mDelay,
                            input logic halt);
        bit to;
        if (traceEnded) return;
        addHandshake(u, 3'd1, fDelay, 1'b0, to);
        if (to) begin
            addHalt(1'b1);
            return;
        end
        addCyc(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, rb(), rb(), rb(), rb(), rb());
        for (int i = 0; i < stalls; i++)
            addCyc(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, rb(), 1'b1, rb(), rb(), rb());
        addCyc(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, rb(), 1'b0, need, store, rb());
        if (need) begin
            addHandshake(u, 3'd4, mDelay, store, to);
            if (to) begin
                addHalt(1'b1);
                return;
            end
        end else if (!skipMem[u]) begin
            addCyc(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 0, rb(), rb(), rb(), rb(), rb());
        end
        addCyc(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 0, rb(), rb(), rb(), rb(), halt);
        if (halt) addHalt(1'b0);
    endtask

    // Random instruction, biased toward short delays with occasional
    // boundary and timeout cases.
    task automatic randInstr(input int u);
        int f, m;
        f = ($urandom % 4 == 0) ? int'($urandom_range(0, maxWait[u] + 1)) : int'($urandom_range(0, 2));
        m = ($urandom % 4 == 0) ? int'($urandom_range(0, maxWait[u] + 1)) : int'($urandom_range(0, 2));
        genInstr(u, f, int'($urandom_range(0, 3)), rb(), rb(), m, logic'($urandom % 6 == 0));
    endtask

    // Each trace starts with the IDLE cycle during which reset is released.
    task automatic startTrace();
        trace.delete();
        traceEnded = 1'b0;
        addCyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, rb(), rb(), rb(), rb(), rb());
    endtask

    // All outputs must read as cleared while reset is asserted.
    task automatic checkReset(input int u, input string tag);
        checkOutput({tag, " state"}, 32'(stateOut[u]), 32'd0);
        checkOutput({tag, " req"}, 32'(reqOut[u]), 32'd0);
        checkOutput({tag, " wr"}, 32'(wrOut[u]), 32'd0);
        checkOutput({tag, " done"}, 32'(doneOut[u]), 32'd0);
        checkOutput({tag, " err"}, 32'(errOut[u]), 32'd0);
        checkOutput({tag, " wait"}, obsWait(u), 32'd0);
`ifdef PROC_SEQ_PERF_EN
        checkOutput({tag, " cyc"}, cycOut[u], 32'd0);
        checkOutput({tag, " ins"}, insOut[u], 32'd0);
        checkOutput({tag, " stl"}, stlOut[u], 32'd0);
`endif
    endtask

    // Replay the trace on unit u: check outputs on each falling edge, then
    // drive that cycle's inputs. Finishes with an asynchronous reset placed
    // between clock edges.
    task automatic applyStimulus(input int u, input int stopAt);
        int n;
        cyc_t r;
        int mCyc, mIns, mStl;
        string tg;
        n = (stopAt < 0 || stopAt > trace.size()) ? trace.size() : stopAt;
        mCyc = 0; mIns = 0; mStl = 0;
        @(negedge clk);
        rstN[u] = 1'b0;
        #1 checkReset(u, $sformatf("u%0d entry-reset", u));
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            r = trace[i];
            tg = $sformatf("u%0d c%0d", u, i);
            checkOutput({tg, " state"}, 32'(stateOut[u]), 32'(r.st));
            checkOutput({tg, " req"}, 32'(reqOut[u]), 32'(r.req));
            checkOutput({tg, " wr"}, 32'(wrOut[u]), 32'(r.wr));
            checkOutput({tg, " done"}, 32'(doneOut[u]), 32'(r.done));
            checkOutput({tg, " err"}, 32'(errOut[u]), 32'(r.err));
            checkOutput({tg, " wait"}, obsWait(u), 32'(r.wcnt));
`ifdef PROC_SEQ_PERF_EN
            checkOutput({tg, " cyc"}, cycOut[u], 32'(mCyc));
            checkOutput({tg, " ins"}, insOut[u], 32'(mIns));
            checkOutput({tg, " stl"}, stlOut[u], 32'(mStl));
`endif
            ackIn[u] = r.ack;
            stallIn[u] = r.stall;
            needIn[u] = r.need;
            storeIn[u] = r.store;
            haltIn[u] = r.halt;
            if (i == 0) rstN[u] = 1'b1;
            if (r.st != 3'd0 && r.st != 3'd6) mCyc++;
            if (r.done) mIns++;
            if ((r.st == 3'd3 && r.stall) || (r.req && !r.ack)) mStl++;
            @(negedge clk);
        end
        if (n < trace.size())
            checkOutput($sformatf("u%0d pre-cut state", u), 32'(stateOut[u]), 32'(trace[n].st));
        #2 rstN[u] = 1'b0;
        #1 checkReset(u, $sformatf("u%0d async-reset", u));
    endtask

    // Index of the first MEM cycle in the current trace.
    function automatic int firstMem();
        foreach (trace[i]) if (trace[i].st == 3'd4) return i;
        return -1;
    endfunction

    // Directed scenarios first, then randomized instruction streams.
    initial begin
        int cut;
        // back-to-back skipped-MEM instructions with immediate acknowledge
        startTrace();
        repeat (3) genInstr(0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(0, -1);
        // store with three wait states in MEM, then a halting load
        startTrace();
        genInstr(0, 0, 0, 1'b1, 1'b1, 3, 1'b0);
        genInstr(0, 1, 0, 1'b1, 1'b0, 0, 1'b1);
        applyStimulus(0, -1);
        // fetch never acknowledged: timeout into HALT with ERR
        startTrace();
        genInstr(0, 11, 0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(0, -1);
        // acknowledge exactly at the threshold, in FETCH and in MEM
        startTrace();
        genInstr(0, 10, 0, 1'b0, 1'b0, 0, 1'b0);
        genInstr(0, 0, 1, 1'b1, 1'b0, 10, 1'b1);
        applyStimulus(0, -1);
        // five stall cycles in EXE, then halt requested in WB
        startTrace();
        genInstr(0, 0, 5, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(0, -1);
        // reset dropped between edges while waiting in MEM
        startTrace();
        genInstr(0, 0, 0, 1'b1, 1'b1, 5, 1'b0);
        cut = firstMem() + 2;
        applyStimulus(0, cut);
        // always-visit-MEM unit: empty MEM pass, then a MEM timeout
        startTrace();
        genInstr(1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        genInstr(1, 3, 1, 1'b0, 1'b1, 0, 1'b0);
        genInstr(1, 0, 0, 1'b1, 1'b0, 4, 1'b0);
        applyStimulus(1, -1);
        // randomized streams alternating between the two units
        for (int seg = 0; seg < 14; seg++) begin
            startTrace();
            for (int k = 0; k < 6; k++) randInstr(seg % 2);
            applyStimulus(seg % 2, (seg % 3 == 2) ? int'($urandom_range(2, trace.size())) : -1);
        end
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
